// File: rtl/vm2413.sv
// Shared types, constants and the feedback averaging helper for the VM2413 OPLL core.
package vm2413;

  localparam int LI_W     = 10;
  localparam int NUM_CH   = 9;
  localparam int NUM_SLOT = 18;

  typedef logic signed [LI_W-1:0] SIGNED_LI_TYPE;

  typedef enum logic {
    FBW_INIT,
    FBW_RUN
  } FBW_STATE;

  // One extra bit of headroom so the mean of two LI samples never wraps.
  function automatic SIGNED_LI_TYPE fb_avg(input SIGNED_LI_TYPE a, input SIGNED_LI_TYPE b);
    logic signed [LI_W:0] sum;
    logic signed [LI_W:0] half;
    sum  = {a[LI_W-1], a} + {b[LI_W-1], b};
    half = sum >>> 1;
    return half[LI_W-1:0];
  endfunction

endpackage

// File: rtl/feedback_writer.sv
// Turns modulator operator outputs into feedback-memory writes; mem_wr two edges after acceptance, no back-pressure once init_done.
// Build option VM2413_FB_AVERAGE_EN: write the mean of current and previous modulator sample instead of the raw sample.
module feedback_writer #(
  parameter int NUM_CH      = vm2413::NUM_CH,
  parameter int INIT_CYCLES = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_slot,
  input  logic [vm2413::LI_W-1:0] in_data,
  output logic                    mem_wr,
  output logic [3:0]              mem_waddr,
  output logic [vm2413::LI_W-1:0] mem_wdata,
  output logic                    bad_slot,
  output logic                    init_done
);
  import vm2413::*;

  localparam int CW = $clog2(INIT_CYCLES + 1);

  FBW_STATE      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          vld_q;
  logic [4:0]    slot_q;
  SIGNED_LI_TYPE data_q;

  logic          is_mod, is_bad;
  logic [3:0]    ch;
  SIGNED_LI_TYPE wdata_d;

  logic          mem_wr_q, bad_slot_q;
  logic [3:0]    waddr_q;
  SIGNED_LI_TYPE wdata_q;

  // Hold-off matches the feedback memory's own clear sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FBW_INIT: begin
        if (cnt_q == CW'(INIT_CYCLES - 1)) state_d = FBW_RUN;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FBW_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == FBW_RUN);
  assign init_done = (state_q == FBW_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      slot_q <= '0;
      data_q <= '0;
    end else begin
      vld_q <= in_valid & in_ready;
      if (in_valid & in_ready) begin
        slot_q <= in_slot;
        data_q <= in_data;
      end
    end
  end

  assign ch     = slot_q[4:1];
  assign is_mod = vld_q && !slot_q[0] && (int'(ch) < NUM_CH);
  assign is_bad = vld_q && (int'(slot_q) >= NUM_SLOT);

`ifdef VM2413_FB_AVERAGE_EN
  SIGNED_LI_TYPE hist_q [NUM_CH];

  // History keeps the raw sample so the next mean uses true operator output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) hist_q[i] <= '0;
    end else if (is_mod) begin
      hist_q[ch] <= data_q;
    end
  end

  assign wdata_d = fb_avg(hist_q[ch], data_q);
`else
  assign wdata_d = data_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wr_q   <= 1'b0;
      bad_slot_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      mem_wr_q   <= is_mod;
      bad_slot_q <= is_bad;
      if (is_mod) begin
        waddr_q <= ch;
        wdata_q <= wdata_d;
      end
    end
  end

  assign mem_wr    = mem_wr_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign bad_slot  = bad_slot_q;

endmodule
